relu_forward: RTL and testbench

RELU_FORWARD -- requirements
Module: relu_forward

---
 rtl/relu_forward_if.sv | 30 +++
 rtl/relu_forward.sv | 195 +++++++++++++++++++
 tb/tb_relu_forward.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/relu_forward_if.sv
// Memory handle shared by the tensor stages: one request channel into a word-addressed memory.
interface mem_handle;
  logic [31:0] region_begin;
  logic [31:0] ptr;
  logic        r_en;
  logic        w_en;
  logic        avail;
  logic [31:0] data_store;
  logic [31:0] data_load;
  logic        read_through;
  logic        write_through;
  logic        done;

  // Handshake: requester drives ptr/data with r_en or w_en plus avail and holds them
  // unchanged until it samples done high; it drops the request in that same cycle.
  modport master_rd (
    input  region_begin, data_load, done,
    output ptr, r_en, w_en, avail, data_store, read_through, write_through
  );

  modport master_wr (
    input  region_begin, done,
    output ptr, r_en, w_en, avail, data_store, read_through, write_through
  );

  modport memory (
    output region_begin, data_load, done,
    input  ptr, r_en, w_en, avail, data_store, read_through, write_through
  );
endinterface

// File: rtl/relu_forward.sv
// Element-wise (leaky) ReLU copying a header-prefixed tensor from handle x to handle y.
module relu_forward #(
  parameter int LEAKY      = 0,
  parameter int LEAK_SHIFT = 4
) (
  input  logic       clk,
  input  logic       rst_l,
  mem_handle.master_rd x,
  mem_handle.master_wr y,
  input  logic       go,
  output logic       done,
  output logic [3:0] state_dbg_o
);

  typedef enum logic [3:0] {
    WAIT, HR0, HW0, HR1, HW1, CNT, RD, WR, DONE
  } relu_state_e;

  relu_state_e state_q, state_d;
  logic        active_q, active_d;
  logic [31:0] rows_q, rows_d;
  logic [31:0] cols_q, cols_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] result_q, result_d;
  logic [31:0] x_ptr_q, x_ptr_d;
  logic        x_req_q, x_req_d;
  logic [31:0] y_ptr_q, y_ptr_d;
  logic        y_req_q, y_req_d;
  logic [31:0] y_data_q, y_data_d;
  logic        y_wt_q, y_wt_d;

  // Kept as its own signed net so the arithmetic shift is not turned unsigned by a ?: context.
  logic signed [31:0] shifted;
  logic        [31:0] relu_v;

  assign shifted = $signed(x.data_load) >>> LEAK_SHIFT;
  assign relu_v  = (x.data_load[31] == 1'b0) ? x.data_load
                 : ((LEAKY != 0) ? shifted : 32'd0);

  // Each access state spends one cycle issuing the request (active_q=0), then waits for done.
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    remaining_d = remaining_q;
    result_d    = result_q;
    x_ptr_d     = x_ptr_q;
    x_req_d     = x_req_q;
    y_ptr_d     = y_ptr_q;
    y_req_d     = y_req_q;
    y_data_d    = y_data_q;
    y_wt_d      = y_wt_q;
    case (state_q)
      WAIT: begin
        if (go) state_d = HR0;
      end
      HR0: begin
        if (!active_q) begin
          x_ptr_d  = x.region_begin;
          y_ptr_d  = y.region_begin;
          x_req_d  = 1'b1;
          active_d = 1'b1;
        end else if (x.done) begin
          rows_d   = x.data_load;
          x_req_d  = 1'b0;
          x_ptr_d  = x_ptr_q + 32'd1;
          active_d = 1'b0;
          state_d  = HW0;
        end
      end
      HW0: begin
        if (!active_q) begin
          y_data_d = rows_q;
          y_req_d  = 1'b1;
          active_d = 1'b1;
        end else if (y.done) begin
          y_req_d  = 1'b0;
          y_ptr_d  = y_ptr_q + 32'd1;
          active_d = 1'b0;
          state_d  = HR1;
        end
      end
      HR1: begin
        if (!active_q) begin
          x_req_d  = 1'b1;
          active_d = 1'b1;
        end else if (x.done) begin
          cols_d   = x.data_load;
          x_req_d  = 1'b0;
          x_ptr_d  = x_ptr_q + 32'd1;
          active_d = 1'b0;
          state_d  = HW1;
        end
      end
      HW1: begin
        if (!active_q) begin
          y_data_d = cols_q;
          y_req_d  = 1'b1;
          active_d = 1'b1;
        end else if (y.done) begin
          y_req_d  = 1'b0;
          y_ptr_d  = y_ptr_q + 32'd1;
          active_d = 1'b0;
          state_d  = CNT;
        end
      end
      CNT: begin
        remaining_d = 32'(rows_q * cols_q);
        state_d     = (remaining_d == 32'd0) ? DONE : RD;
      end
      RD: begin
        if (!active_q) begin
          x_req_d  = 1'b1;
          active_d = 1'b1;
        end else if (x.done) begin
          result_d = relu_v;
          x_req_d  = 1'b0;
          x_ptr_d  = x_ptr_q + 32'd1;
          active_d = 1'b0;
          state_d  = WR;
        end
      end
      WR: begin
        if (!active_q) begin
          y_data_d = result_q;
          y_wt_d   = (remaining_q == 32'd1);
          y_req_d  = 1'b1;
          active_d = 1'b1;
        end else if (y.done) begin
          y_req_d     = 1'b0;
          y_wt_d      = 1'b0;
          y_ptr_d     = y_ptr_q + 32'd1;
          remaining_d = remaining_q - 32'd1;
          active_d    = 1'b0;
          state_d     = (remaining_q != 32'd1) ? RD : DONE;
        end
      end
      DONE: begin
        if (!go) state_d = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= WAIT;
      active_q    <= 1'b0;
      rows_q      <= '0;
      cols_q      <= '0;
      remaining_q <= '0;
      result_q    <= '0;
      x_ptr_q     <= '0;
      x_req_q     <= 1'b0;
      y_ptr_q     <= '0;
      y_req_q     <= 1'b0;
      y_data_q    <= '0;
      y_wt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      remaining_q <= remaining_d;
      result_q    <= result_d;
      x_ptr_q     <= x_ptr_d;
      x_req_q     <= x_req_d;
      y_ptr_q     <= y_ptr_d;
      y_req_q     <= y_req_d;
      y_data_q    <= y_data_d;
      y_wt_q      <= y_wt_d;
    end
  end

  assign x.ptr           = x_ptr_q;
  assign x.r_en          = x_req_q;
  assign x.w_en          = 1'b0;
  assign x.avail         = x_req_q;
  assign x.data_store    = 32'd0;
  assign x.read_through  = 1'b0;
  assign x.write_through = 1'b0;

  assign y.ptr           = y_ptr_q;
  assign y.r_en          = 1'b0;
  assign y.w_en          = y_req_q;
  assign y.avail         = y_req_q;
  assign y.data_store    = y_data_q;
  assign y.read_through  = 1'b0;
  assign y.write_through = y_wt_q;

  assign done        = (state_q == DONE);
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_relu_forward.sv
// Bench for relu_forward: plain and leaky instances sharing one stalling memory model.
module tb_relu_forward;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_l;
  logic       go_r [2];
  logic       done_w [2];
  logic [3:0] st_w [2];

  // Handles 0/1 are x/y of the plain instance, 2/3 of the leaky instance.
  mem_handle hx [4] ();

  relu_forward #(.LEAKY(0), .LEAK_SHIFT(4)) u_plain (
    .clk(clk), .rst_l(rst_l), .x(hx[0]), .y(hx[1]),
    .go(go_r[0]), .done(done_w[0]), .state_dbg_o(st_w[0])
  );

  relu_forward #(.LEAKY(1), .LEAK_SHIFT(4)) u_leaky (
    .clk(clk), .rst_l(rst_l), .x(hx[2]), .y(hx[3]),
    .go(go_r[1]), .done(done_w[1]), .state_dbg_o(st_w[1])
  );

  logic [31:0] p_ptr [4];
  logic [31:0] p_data [4];
  logic [31:0] p_load [4];
  logic [31:0] p_base [4];
  logic        p_ren [4];
  logic        p_wen [4];
  logic        p_avail [4];
  logic        p_rt [4];
  logic        p_wt [4];
  logic        p_done [4];

  for (genvar g = 0; g < 4; g++) begin : g_port
    assign p_ptr[g]           = hx[g].ptr;
    assign p_data[g]          = hx[g].data_store;
    assign p_ren[g]           = hx[g].r_en;
    assign p_wen[g]           = hx[g].w_en;
    assign p_avail[g]         = hx[g].avail;
    assign p_rt[g]            = hx[g].read_through;
    assign p_wt[g]            = hx[g].write_through;
    assign hx[g].done         = p_done[g];
    assign hx[g].data_load    = p_load[g];
    assign hx[g].region_begin = p_base[g];
  end

  logic [31:0] mem [256];
  logic [64:0] exp_q [$];   // {write_through, addr, data} per expected y write
  logic [31:0] img_q [$];   // expected final y region
  logic [31:0] src_q [$];
  int          cur_yb;
  int          stall_max;
  logic        busy [4];
  int          wcnt [4];
  logic [68:0] snap [4];
  int          rd_cnt [4];
  int          wr_cnt [4];
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [68:0] cur_sig(input int g);
    return {p_ptr[g], p_data[g], p_ren[g], p_wen[g], p_avail[g], p_rt[g], p_wt[g]};
  endfunction

  // Reference: non-negative passes, negative is 0 or floor(v / 16).
  function automatic logic [31:0] relu_ref(input logic [31:0] v, input bit leaky);
    longint sv, q;
    sv = longint'($signed(v));
    if (sv >= 0) return v;
    if (!leaky) return 32'd0;
    q = sv / 16;
    if (q * 16 != sv) q = q - 1;
    return q[31:0];
  endfunction

  task automatic serve(input int g);
    logic [64:0] e;
    if (p_ren[g]) begin
      p_load[g] = mem[p_ptr[g][7:0]];
      rd_cnt[g]++;
    end else begin
      if (exp_q.size() == 0) begin
        check("extra_write", 69'(p_ptr[g]), 69'h1_0000_0000);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 69'(p_ptr[g]), 69'(e[63:32]));
        check("wr_data", 69'(p_data[g]), 69'(e[31:0]));
        check("wr_through", 69'(p_wt[g]), 69'(e[64]));
      end
      mem[p_ptr[g][7:0]] = p_data[g];
      wr_cnt[g]++;
    end
  endtask

  // Memory responder: acts on the falling edge, so done/data_load settle before the DUT samples.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (!rst_l) begin
        p_done[g] = 1'b0;
        busy[g]   = 1'b0;
        wcnt[g]   = 0;
      end else if (p_done[g]) begin
        p_done[g] = 1'b0;
        busy[g]   = 1'b0;
      end else if (p_ren[g] || p_wen[g]) begin
        if (!busy[g]) begin
          busy[g] = 1'b1;
          snap[g] = cur_sig(g);
          wcnt[g] = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
          check("rw_excl", 69'(p_ren[g] & p_wen[g]), 69'd0);
          check("avail_with_req", 69'(p_avail[g]), 69'd1);
          check("read_through", 69'(p_rt[g]), 69'd0);
          if (g % 2 == 0) check("x_no_write", 69'(p_wen[g]), 69'd0);
          else            check("y_no_read", 69'(p_ren[g]), 69'd0);
        end else begin
          check("hold_stable", cur_sig(g), snap[g]);
        end
        if (wcnt[g] == 0) begin
          p_done[g] = 1'b1;
          serve(g);
        end else begin
          wcnt[g]--;
        end
      end
    end
  end

  task automatic fill_src(input int n);
    src_q.delete();
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(4, 0))
        0:       src_q.push_back($urandom);
        1:       src_q.push_back(32'h8000_0000);
        2:       src_q.push_back(32'hFFFF_FFFF);
        3:       src_q.push_back(32'($urandom_range(100, 0)));
        default: src_q.push_back(-32'($urandom_range(100, 1)));
      endcase
    end
  endtask

  task automatic prep(input int d, input int rows, input int cols, input int stall, input bit alias_xy);
    int n, xb, yb;
    logic [31:0] r;
    n  = rows * cols;
    xb = int'($urandom_range(15, 8));
    yb = alias_xy ? xb : int'($urandom_range(120, 100));
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[xb]     = 32'(rows);
    mem[xb + 1] = 32'(cols);
    for (int i = 0; i < n; i++) mem[xb + 2 + i] = src_q[i];
    exp_q.delete();
    img_q.delete();
    exp_q.push_back({1'b0, 32'(yb), 32'(rows)});
    exp_q.push_back({1'b0, 32'(yb + 1), 32'(cols)});
    img_q.push_back(32'(rows));
    img_q.push_back(32'(cols));
    for (int i = 0; i < n; i++) begin
      r = relu_ref(src_q[i], d == 1);
      exp_q.push_back({(i == n - 1), 32'(yb + 2 + i), r});
      img_q.push_back(r);
    end
    cur_yb          = yb;
    p_base[2*d]     = 32'(xb);
    p_base[2*d + 1] = 32'(yb);
    stall_max       = stall;
    rd_cnt[2*d]     = 0;
    wr_cnt[2*d + 1] = 0;
  endtask

  task automatic run_case(input int d, input int rows, input int cols, input int stall, input bit alias_xy);
    int cyc;
    prep(d, rows, cols, stall, alias_xy);
    @(negedge clk);
    go_r[d] = 1'b1;
    cyc = 0;
    while (!done_w[d] && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_reached", 69'(done_w[d]), 69'd1);
    check("writes_left", 69'(exp_q.size()), 69'd0);
    check("read_count", 69'(rd_cnt[2*d]), 69'(2 + rows * cols));
    for (int i = 0; i < img_q.size(); i++)
      check("y_mem", 69'(mem[cur_yb + i]), 69'(img_q[i]));
    repeat (2) begin
      @(negedge clk);
      check("done_held", 69'(done_w[d]), 69'd1);
    end
    go_r[d] = 1'b0;
    @(posedge clk);
    #1;
    check("done_drop", 69'(done_w[d]), 69'd0);
  endtask

  initial begin
    int cyc;
    n_checks = 0;
    n_pass   = 0;
    rst_l    = 1'b0;
    go_r[0]  = 1'b0;
    go_r[1]  = 1'b0;
    stall_max = 0;
    for (int g = 0; g < 4; g++) begin
      p_done[g] = 1'b0;
      p_load[g] = '0;
      p_base[g] = '0;
      busy[g]   = 1'b0;
      wcnt[g]   = 0;
      rd_cnt[g] = 0;
      wr_cnt[g] = 0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) check("reset_handle", cur_sig(g), 69'd0);
    check("reset_done0", 69'(done_w[0]), 69'd0);
    check("reset_done1", 69'(done_w[1]), 69'd0);
    #2 rst_l = 1'b1;

    src_q = '{32'd5, -32'd3, 32'd0, 32'd7, -32'd1, 32'h7FFF_FFFF};
    run_case(0, 2, 3, 0, 1'b0);

    src_q = '{-32'd32, -32'd1, 32'd16};
    run_case(1, 1, 3, 0, 1'b0);

    src_q.delete();
    run_case(0, 0, 9, 0, 1'b0);
    check("no_elem_writes", 69'(wr_cnt[1]), 69'd2);

    src_q = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd1};
    run_case(0, 2, 2, 2, 1'b0);
    run_case(1, 2, 2, 2, 1'b0);

    for (int d = 0; d < 2; d++) begin
      fill_src(12);
      run_case(d, 3, 4, 0, 1'b0);
      run_case(d, 3, 4, 7, 1'b0);
    end

    fill_src(6);
    run_case(1, 3, 2, 5, 1'b1);
    fill_src(6);
    run_case(0, 2, 3, 3, 1'b1);

    // Reset while the third element write is waiting on the memory.
    src_q = '{32'd1, -32'd2, 32'd3, -32'd4, 32'd5, -32'd6};
    prep(0, 2, 3, 3, 1'b0);
    @(negedge clk);
    go_r[0] = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!(wr_cnt[1] == 4 && p_wen[1]) && cyc < 2000);
    check("third_wr_reached", 69'(wr_cnt[1] == 4 && p_wen[1]), 69'd1);
    rst_l   = 1'b0;
    go_r[0] = 1'b0;
    #1;
    check("midrst_x", cur_sig(0), 69'd0);
    check("midrst_y", cur_sig(1), 69'd0);
    check("midrst_done", 69'(done_w[0]), 69'd0);
    @(negedge clk);
    #2 rst_l = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_rst_x", cur_sig(0), 69'd0);
    check("idle_after_rst_y", cur_sig(1), 69'd0);
    run_case(0, 2, 3, 3, 1'b0);

    for (int t = 0; t < 6; t++) begin
      int rows, cols;
      rows = int'($urandom_range(4, 0));
      cols = int'($urandom_range(4, 0));
      fill_src(rows * cols);
      run_case(t % 2, rows, cols, int'($urandom_range(7, 0)), 1'(t == 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
